// File: rtl/convertidor_ps_pkg.sv
// Shared PHY definitions for the serial link (transmitter and receiver sides).
package convertidor_ps_pkg;

    localparam int unsigned BYTE_W = 8;

    // Sync/idle byte, also matched by the receiver's comma detector.
    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic {
        StSync   = 1'b0,
        StActive = 1'b1
    } state_e;

endpackage

// File: rtl/convertidor_ps_if.sv
// Byte-side handshake and serial-side outputs of the parallel-to-serial transmitter.
interface convertidor_ps_if;
    import convertidor_ps_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              ready;
    logic              data_out;
    logic              active;
    logic [7:0]        tx_count;

    // Upstream byte source / observer
    modport master (
        output data_in,
        output valid_in,
        input  ready,
        input  data_out,
        input  active,
        input  tx_count
    );

    // Transmitter
    modport slave (
        input  data_in,
        input  valid_in,
        output ready,
        output data_out,
        output active,
        output tx_count
    );

endinterface

// File: rtl/ps_shift_reg.sv
// Serialiser datapath: free-running bit counter plus MSB-first shift register.
module ps_shift_reg
    import convertidor_ps_pkg::*;
(
    input  logic              clk_8f,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_byte,
    output logic              data_out,
    output logic [2:0]        bit_cnt
);

    logic [BYTE_W-1:0] shreg_q;
    logic              data_out_q;
    logic [2:0]        bit_cnt_q;

    // Bit counter wraps every byte; boundary is where it reads zero.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            bit_cnt_q <= 3'd0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    // On load the MSB goes straight out and the rest is staged; otherwise keep shifting.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            shreg_q    <= '0;
            data_out_q <= 1'b0;
        end else if (load) begin
            shreg_q    <= load_byte << 1;
            data_out_q <= load_byte[BYTE_W-1];
        end else begin
            shreg_q    <= shreg_q << 1;
            data_out_q <= shreg_q[BYTE_W-1];
        end
    end

    assign data_out = data_out_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/convertidor_ps.sv
// Parallel-to-serial PHY transmitter: comma preamble after reset, then data or idle commas.
module convertidor_ps #(
    parameter int unsigned BC_COUNT = 4,
    parameter logic [7:0]  COMMA    = convertidor_ps_pkg::COMMA
) (
    input  logic             clk_8f,
    input  logic             reset,
    convertidor_ps_if.slave  tx
);
    import convertidor_ps_pkg::*;

    localparam logic [3:0] SYNC_LAST = 4'(BC_COUNT - 1);

    state_e            state_q, state_d;
    logic [3:0]        sync_cnt_q;
    logic [7:0]        tx_count_q;
    logic [2:0]        bit_cnt;
    logic              boundary;
    logic              ready;
    logic              consume;
    logic [BYTE_W-1:0] byte_sel;

    assign boundary = (bit_cnt == 3'd0);

    ps_shift_reg u_shift (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .load      (boundary),
        .load_byte (byte_sel),
        .data_out  (tx.data_out),
        .bit_cnt   (bit_cnt)
    );

    // State register.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave the preamble on the boundary that sends the last comma; ACTIVE is sticky.
    always_comb begin
        state_d = state_q;
        if (state_q == StSync && boundary && sync_cnt_q == SYNC_LAST) begin
            state_d = StActive;
        end
    end

    // Handshake and byte select; ready depends on registers only.
    always_comb begin
        ready    = 1'b0;
        consume  = 1'b0;
        byte_sel = COMMA;
        if (state_q == StActive && boundary) begin
            ready = 1'b1;
            if (tx.valid_in) begin
                consume  = 1'b1;
                byte_sel = tx.data_in;
            end
        end
    end

    // Preamble byte counter.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            sync_cnt_q <= 4'd0;
        end else if (state_q == StSync && boundary) begin
            sync_cnt_q <= sync_cnt_q + 4'd1;
        end
    end

    // Consumed data byte counter; wraps silently.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            tx_count_q <= 8'd0;
        end else if (consume) begin
            tx_count_q <= tx_count_q + 8'd1;
        end
    end

    assign tx.ready    = ready;
    assign tx.active   = (state_q == StActive);
    assign tx.tx_count = tx_count_q;

endmodule

// File: tb/tb_convertidor_ps.sv
// Scoreboard bench: byte slots push expected serial bits, a negedge monitor pops and compares.
module tb_convertidor_ps;

    logic clk_8f = 1'b0;
    logic reset  = 1'b0;

    convertidor_ps_if bus_if ();

    convertidor_ps #(
        .BC_COUNT (4),
        .COMMA    (8'hBC)
    ) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .tx     (bus_if)
    );

    always #5 clk_8f = ~clk_8f;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         edge_n = 0;
    logic       exp_q[$];
    logic       mon_exp;
    logic [7:0] exp_tx = 8'd0;

    // Edges since reset release; the first serial bit is valid after edge 1.
    always @(posedge clk_8f or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Monitor: every cycle after release carries one expected serial bit.
    always @(negedge clk_8f) begin
        if (reset && edge_n > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL serial_underflow: edge %0d got %b, required nothing queued",
                         edge_n, bus_if.data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus_if.data_out !== mon_exp) begin
                    n_bad++;
                    $display("FAIL serial_bit: edge %0d got %b, required %b",
                             edge_n, bus_if.data_out, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
    endtask

    // Called just before a boundary edge; scrambles inputs on the following non-boundary edges.
    task automatic slot(input logic v, input logic [7:0] d, input logic exp_rdy,
                        input logic exp_act);
        bus_if.valid_in = v;
        bus_if.data_in  = d;
        #1;
        check("ready_at_boundary", 32'(bus_if.ready), 32'(exp_rdy));
        if (exp_rdy && v) begin
            push_byte(d);
            exp_tx = exp_tx + 8'd1;
        end else begin
            push_byte(8'hBC);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_8f);
            #2;
            if (i == 0) begin
                check("active", 32'(bus_if.active), 32'(exp_act));
                check("tx_count", 32'(bus_if.tx_count), 32'(exp_tx));
            end
            if (i == 3) check("ready_mid_byte", 32'(bus_if.ready), 32'd0);
            if (i < 7) begin
                bus_if.data_in  = 8'($urandom);
                bus_if.valid_in = 1'($urandom);
            end
        end
    endtask

    task automatic preamble();
        slot(1'b1, 8'h77, 1'b0, 1'b0);
        slot(1'b0, 8'h00, 1'b0, 1'b0);
        slot(1'b1, 8'h12, 1'b0, 1'b0);
        slot(1'b0, 8'h00, 1'b0, 1'b1);  // 4th comma: active rises on edge 25
    endtask

    initial begin
        bus_if.valid_in = 1'b0;
        bus_if.data_in  = 8'h00;
        repeat (3) @(posedge clk_8f);
        #2;
        check("reset_data_out", 32'(bus_if.data_out), 32'd0);
        check("reset_active", 32'(bus_if.active), 32'd0);
        check("reset_ready", 32'(bus_if.ready), 32'd0);
        check("reset_tx_count", 32'(bus_if.tx_count), 32'd0);
        reset = 1'b1;

        preamble();
        slot(1'b1, 8'hA5, 1'b1, 1'b1);
        slot(1'b1, 8'h00, 1'b1, 1'b1);
        slot(1'b1, 8'hFF, 1'b1, 1'b1);
        slot(1'b1, 8'h3C, 1'b1, 1'b1);
        slot(1'b0, 8'h11, 1'b1, 1'b1);  // idle fill
        slot(1'b0, 8'hEE, 1'b1, 1'b1);  // idle fill
        slot(1'b1, 8'h5A, 1'b1, 1'b1);

        // 251 more bytes bring the count to 256, i.e. wrap to 0.
        for (int i = 0; i < 251; i++) slot(1'b1, 8'(i * 7 + 3), 1'b1, 1'b1);
        check("tx_count_wrapped", 32'(bus_if.tx_count), 32'd0);

        // Reset in the middle of an active byte.
        bus_if.valid_in = 1'b1;
        bus_if.data_in  = 8'hC3;
        #1;
        check("ready_before_abort", 32'(bus_if.ready), 32'd1);
        push_byte(8'hC3);
        exp_tx = exp_tx + 8'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_8f);
            #2;
        end
        reset = 1'b0;
        #1;
        check("abort_data_out", 32'(bus_if.data_out), 32'd0);
        check("abort_active", 32'(bus_if.active), 32'd0);
        check("abort_ready", 32'(bus_if.ready), 32'd0);
        check("abort_tx_count", 32'(bus_if.tx_count), 32'd0);
        exp_q.delete();
        exp_tx = 8'd0;
        repeat (3) @(posedge clk_8f);
        #2;
        reset = 1'b1;

        preamble();
        slot(1'b1, 8'h96, 1'b1, 1'b1);
        check("tx_count_after_restart", 32'(bus_if.tx_count), 32'd1);

        #4;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
